lfsr_encrypt_ctrl: RTL
======================

LFSR_ENCRYPT_CTRL -- requirements
Module: lfsr_encrypt_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1 bit: high holds the block idle; a high-to-low transition launches one encryption run.
REQ-004 SHALL have port Ack, output, 1 bit: run complete; registered.
REQ-005 SHALL have port DmAddr, output, 8 bits: data memory address.
REQ-006 SHALL have port DmWrEn, output, 1 bit: data memory write enable; the write occurs on the rising edge.
REQ-007 SHALL have port DmWrData, output, 8 bits: data memory write data.
REQ-008 SHALL have port DmRdData, input, 8 bits: data memory read data; combinational read of DmAddr, valid in the same cycle.
REQ-009 SHALL have parameter MSG_BASE, default 0: base address of the plaintext.
REQ-010 SHALL have parameter CFG_BASE, default 61: address of the preamble length; tap index at +1, LFSR seed at +2.
REQ-011 SHALL have parameter OUT_BASE, default 64: base address of the 64 ciphertext bytes.

Function
REQ-012 SHALL implement FSM states IDLE, RD_PRE, RD_TAP, RD_INIT, RD_CHR, WR_CHR, DONE.
REQ-013 SHALL register Start as start_q and launch from IDLE only when start_q=1 and Start=0 at an edge; the next state is RD_PRE.
REQ-014 SHALL, in RD_PRE: DmAddr=CFG_BASE; capture pre = clamp(DmRdData): values <10 become 10, values >26 become 26, otherwise unchanged.
REQ-015 SHALL, in RD_TAP: DmAddr=CFG_BASE+1; index k = 8 if DmRdData==8, else DmRdData[2:0]; capture taps from the table {0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B}[k].
REQ-016 SHALL, in RD_INIT: DmAddr=CFG_BASE+2; lfsr <= DmRdData[6:0], with 0 replaced by 0x01; i <= 0.
REQ-017 SHALL, in RD_CHR: if i<pre, plaintext byte p=0x20 and DmAddr is don't-care; else DmAddr=MSG_BASE+(i-pre) and p=DmRdData; capture p.
REQ-018 SHALL, in WR_CHR: DmWrEn=1, DmAddr=OUT_BASE+i, c[6:0]=p[6:0]^lfsr, c[7]=XOR-reduce(c[6:0]), DmWrData=c.
REQ-019 SHALL, at the WR_CHR edge, update lfsr <= {lfsr[5:0], XOR-reduce(lfsr & taps)} and i <= i+1; i uses a 7-bit counter.
REQ-020 SHALL go from WR_CHR to RD_CHR when i<63 and to DONE when i==63; exactly 64 writes occur per run.
REQ-021 SHALL compute p[7] into c only through parity: the plaintext MSB is discarded.
REQ-022 SHALL hold DmWrEn=0 in every state other than WR_CHR.
REQ-023 SHALL drive Ack=1 exactly while in DONE; DONE returns to IDLE when Start=1 is sampled.
REQ-024 SHALL ignore Start during RD_PRE..WR_CHR; a run is not aborted or restarted by Start.
REQ-025 SHALL have latency from launch edge E0 to the Ack rise of exactly 131 cycles; character i is written at edge E0+5+2i.
REQ-026 SHALL have no combinational path from Start or DmRdData to Ack; DmAddr, DmWrEn and DmWrData are decoded from registers only, except that DmWrData uses captured p.
REQ-027 SHALL stay in IDLE with Start held low after DONE->IDLE until a new high-to-low transition occurs.

Reset
REQ-028 SHALL, with Reset low, asynchronously force state=IDLE, Ack=0, DmWrEn=0, DmAddr=0, DmWrData=0, start_q=0, i=0, lfsr=0, pre=0, taps=0.
REQ-029 SHALL, on Reset low mid-run, suppress any write in that cycle; no partial result is resumed after release.
REQ-030 SHALL, with start_q=0 after reset, not launch a run while Start is low out of reset; Start must be seen high first.

Verification
REQ-031 Basic: DM[61]=10, DM[62]=0, DM[63]=0x01, DM[0..60]=0x20; Start 1->0 -> DM[64]=0x21, DM[65]=0x22, Ack high 131 cycles after launch.
REQ-032 Clamp: DM[61]=5 -> DM[74]=encrypt(DM[0]); DM[61]=40 -> DM[90]=encrypt(DM[0]); DM[64..73] encrypt 0x20 in both cases.
REQ-033 Taps: DM[62]=8 -> pattern 0x7B; DM[62]=0x0B -> index 3 (0x72); all 64 bytes match the golden LFSR model.
REQ-034 Seed: DM[63]=0x00 -> identical output to DM[63]=0x01; DM[63]=0xFF -> seed 0x7F.
REQ-035 Reset mid-run: Reset low at i=20 during WR_CHR -> no write, Ack=0, IDLE; new Start fall -> full correct run.
REQ-036 Handshake: Start toggled high mid-run -> ignored, Ack at cycle 131; Start high in DONE -> Ack drops next cycle; Start held low -> no relaunch.

Source files
------------

// File: rtl/lfsr_encrypt_ctrl.sv
// LFSR stream encryptor: reads preamble length, tap select and seed from data memory,
// then writes 64 parity-tagged ciphertext bytes (preamble spaces followed by the message).
module lfsr_encrypt_ctrl #(
   parameter int MSG_BASE = 0,
   parameter int CFG_BASE = 61,
   parameter int OUT_BASE = 64
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   output logic       Ack,
   output logic [7:0] DmAddr,
   output logic       DmWrEn,
   output logic [7:0] DmWrData,
   input  logic [7:0] DmRdData,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_PRE  = 3'd1,
      RD_TAP  = 3'd2,
      RD_INIT = 3'd3,
      RD_CHR  = 3'd4,
      WR_CHR  = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [7:0] MSG_A  = 8'(MSG_BASE);
   localparam logic [7:0] PRE_A  = 8'(CFG_BASE);
   localparam logic [7:0] TAP_A  = 8'(CFG_BASE + 1);
   localparam logic [7:0] SEED_A = 8'(CFG_BASE + 2);
   localparam logic [7:0] OUT_A  = 8'(OUT_BASE);

   state_t     state;
   logic       start_q;
   logic [6:0] i;
   logic [6:0] lfsr;
   logic [4:0] pre;
   logic [6:0] taps;
   logic [6:0] p;

   logic [4:0] pre_clamp;
   logic [3:0] tap_idx;
   logic [6:0] tap_sel;
   logic [6:0] seed;
   logic       in_preamble;
   logic [6:0] msg_off;
   logic [6:0] c_low;

   always_comb begin
      pre_clamp = DmRdData[4:0];
      if (DmRdData < 8'd10)
         pre_clamp = 5'd10;
      else if (DmRdData > 8'd26)
         pre_clamp = 5'd26;
   end

   // Selector 8 is the only value above 7 that maps to its own entry.
   assign tap_idx = (DmRdData == 8'd8) ? 4'd8 : {1'b0, DmRdData[2:0]};

   always_comb begin
      tap_sel = 7'h60;
      case (tap_idx)
         4'd0:    tap_sel = 7'h60;
         4'd1:    tap_sel = 7'h48;
         4'd2:    tap_sel = 7'h78;
         4'd3:    tap_sel = 7'h72;
         4'd4:    tap_sel = 7'h6A;
         4'd5:    tap_sel = 7'h69;
         4'd6:    tap_sel = 7'h5C;
         4'd7:    tap_sel = 7'h7E;
         4'd8:    tap_sel = 7'h7B;
         default: tap_sel = 7'h60;
      endcase
   end

   assign seed        = (DmRdData[6:0] == 7'd0) ? 7'h01 : DmRdData[6:0];
   assign in_preamble = (i < {2'b00, pre});
   assign msg_off     = i - {2'b00, pre};
   assign c_low       = p ^ lfsr;
   assign dbg_state   = state;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         Ack     <= 1'b0;
         start_q <= 1'b0;
         i       <= '0;
         lfsr    <= '0;
         pre     <= '0;
         taps    <= '0;
         p       <= '0;
      end else begin
         start_q <= Start;
         case (state)
            IDLE: begin
               if (start_q && !Start)
                  state <= RD_PRE;
            end
            RD_PRE: begin
               pre   <= pre_clamp;
               state <= RD_TAP;
            end
            RD_TAP: begin
               taps  <= tap_sel;
               state <= RD_INIT;
            end
            RD_INIT: begin
               lfsr  <= seed;
               i     <= '0;
               state <= RD_CHR;
            end
            RD_CHR: begin
               // Plaintext MSB never reaches the ciphertext, so only 7 bits are kept.
               p     <= in_preamble ? 7'h20 : DmRdData[6:0];
               state <= WR_CHR;
            end
            WR_CHR: begin
               lfsr <= {lfsr[5:0], ^(lfsr & taps)};
               i    <= i + 7'd1;
               if (i == 7'd63) begin
                  state <= DONE;
                  Ack   <= 1'b1;
               end else begin
                  state <= RD_CHR;
               end
            end
            DONE: begin
               if (Start) begin
                  state <= IDLE;
                  Ack   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Ack   <= 1'b0;
            end
         endcase
      end
   end

   // Memory-side outputs decode purely from registered state.
   always_comb begin
      DmAddr   = 8'd0;
      DmWrEn   = 1'b0;
      DmWrData = 8'd0;
      case (state)
         RD_PRE:  DmAddr = PRE_A;
         RD_TAP:  DmAddr = TAP_A;
         RD_INIT: DmAddr = SEED_A;
         RD_CHR:  DmAddr = in_preamble ? MSG_A : (MSG_A + {1'b0, msg_off});
         WR_CHR: begin
            DmAddr   = OUT_A + {1'b0, i};
            DmWrEn   = 1'b1;
            DmWrData = {^c_low, c_low};
         end
         default: DmAddr = 8'd0;
      endcase
   end

endmodule
